sl_transmitter: RTL

Clocked serial-link (SL) two-wire transmitter. It takes one parallel word per handshake and drives it onto sl0/sl1 as active-low pulses: a bit 0 pulses sl0, a bit 1 pulses sl1. Each frame is 8, 16 or 32 data bits, then one odd-parity bit, then a stop condition (both lines low together). It sits directly upstream of the SL receiver and feeds its sl0/sl1 inputs. Because that receiver is edge-clocked on both lines, both outputs are glitch-free registers.

---
 rtl/sl_pkg.sv | 47 ++++
 rtl/sl_phase_timer.sv | 39 +++
 rtl/sl_transmitter.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/sl_pkg.sv
// Shared types and helpers for the serial-link (SL) transmitter and receiver.
//   sl_mode_t     : word-size selector carried on the 2-bit mode port
//   tx_state_t    : transmitter frame-sequencing states
//   sl_nbits      : data bits per frame for a mode (0 for the invalid mode)
//   sl_odd_parity : parity bit that makes the count of ones (data + parity) odd
package sl_pkg;

    localparam int unsigned SL_DATA_W = 32;
    localparam int unsigned SL_IDX_W  = 6;

    typedef enum logic [1:0] {
        SL_8   = 2'd0,
        SL_16  = 2'd1,
        SL_32  = 2'd2,
        SL_BAD = 2'd3
    } sl_mode_t;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        PULSE    = 3'd1,
        GAP      = 3'd2,
        STOP     = 3'd3,
        STOP_GAP = 3'd4
    } tx_state_t;

    // Data bits per frame; 6 bits wide so that 32 is representable.
    function automatic logic [SL_IDX_W-1:0] sl_nbits(input sl_mode_t mode);
        case (mode)
            SL_8:    return SL_IDX_W'(8);
            SL_16:   return SL_IDX_W'(16);
            SL_32:   return SL_IDX_W'(32);
            default: return SL_IDX_W'(0);
        endcase
    endfunction

    // Odd parity over the active low bits of the word.
    function automatic logic sl_odd_parity(input logic [SL_DATA_W-1:0] data,
                                           input sl_mode_t mode);
        case (mode)
            SL_8:    return ~^data[7:0];
            SL_16:   return ~^data[15:0];
            SL_32:   return ~^data;
            default: return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/sl_phase_timer.sv
// Down-counting phase timer shared by the pulse and gap phases.
//   clk, reset  : clock, async active-high reset
//   load_i      : load load_val_i (takes priority over counting)
//   load_val_i  : phase length minus one
//   tc_c_o      : terminal count, high while the counter is zero
module sl_phase_timer #(
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic         tc_c_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Load wins; otherwise count down and park at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_c_o = (cnt_q == '0);

endmodule

// File: rtl/sl_transmitter.sv
// SL two-wire transmitter: sends one 8/16/32-bit word per handshake, LSB first,
// as active-low pulses (sl0 for a 0, sl1 for a 1), followed by an odd-parity
// bit and a stop condition (both lines low).
//   clk, reset : clock, async active-high reset
//   mode       : word size (0=8, 1=16, 2=32, 3=invalid)
//   tx_data    : word to send, low N bits used
//   tx_valid   : word/mode valid
//   tx_ready   : word can be accepted this cycle
//   sl0, sl1   : registered line outputs, idle high
//   busy       : frame in progress
//   done       : one-cycle pulse after the frame completes
module sl_transmitter
    import sl_pkg::*;
#(
    parameter int unsigned PULSE_LEN = 4,
    parameter int unsigned GAP_LEN   = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  mode,
    input  logic [31:0] tx_data,
    input  logic        tx_valid,
    output logic        tx_ready,
    output logic        sl0,
    output logic        sl1,
    output logic        busy,
    output logic        done
);

    localparam int unsigned TMR_MAX = (PULSE_LEN > GAP_LEN) ? PULSE_LEN : GAP_LEN;
    localparam int unsigned TMR_W   = $clog2(TMR_MAX) + 1;

    tx_state_t               state_q;
    logic [SL_DATA_W-1:0]    shift_q;
    logic [SL_IDX_W-1:0]     nbits_q;
    logic [SL_IDX_W-1:0]     idx_q;
    logic                    parity_q;
    logic                    sl0_q;
    logic                    sl1_q;
    logic                    busy_q;
    logic                    done_q;

    logic                    accept_c;
    logic                    next_bit_c;
    logic                    tmr_load_c;
    logic [TMR_W-1:0]        tmr_val_c;
    logic                    tmr_tc_c;

    assign tx_ready = (state_q == IDLE) && (mode != 2'd3) && !reset;
    assign accept_c = tx_valid && tx_ready;

    // Bit sent after the current gap: parity once all data bits are out.
    assign next_bit_c = ((idx_q + SL_IDX_W'(1)) == nbits_q) ? parity_q : shift_q[0];

    // Reload at every phase boundary; pulse/stop are followed by a gap, all else by a pulse.
    assign tmr_load_c = accept_c ||
                        (tmr_tc_c && (state_q != IDLE) && (state_q != STOP_GAP));
    assign tmr_val_c  = ((state_q == PULSE) || (state_q == STOP)) ?
                        TMR_W'(GAP_LEN - 1) : TMR_W'(PULSE_LEN - 1);

    sl_phase_timer #(
        .W (TMR_W)
    ) u_timer (
        .clk        (clk),
        .reset      (reset),
        .load_i     (tmr_load_c),
        .load_val_i (tmr_val_c),
        .tc_c_o     (tmr_tc_c)
    );

    // Frame sequencer; lines are driven straight from registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            shift_q  <= '0;
            nbits_q  <= '0;
            idx_q    <= '0;
            parity_q <= 1'b0;
            sl0_q    <= 1'b1;
            sl1_q    <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept_c) begin
                        shift_q  <= tx_data;
                        nbits_q  <= sl_nbits(sl_mode_t'(mode));
                        parity_q <= sl_odd_parity(tx_data, sl_mode_t'(mode));
                        idx_q    <= '0;
                        busy_q   <= 1'b1;
                        sl0_q    <= tx_data[0];
                        sl1_q    <= ~tx_data[0];
                        state_q  <= PULSE;
                    end
                end
                PULSE: begin
                    if (tmr_tc_c) begin
                        sl0_q   <= 1'b1;
                        sl1_q   <= 1'b1;
                        shift_q <= shift_q >> 1;
                        state_q <= GAP;
                    end
                end
                GAP: begin
                    if (tmr_tc_c) begin
                        if (idx_q == nbits_q) begin
                            sl0_q   <= 1'b0;
                            sl1_q   <= 1'b0;
                            state_q <= STOP;
                        end else begin
                            idx_q   <= idx_q + SL_IDX_W'(1);
                            sl0_q   <= next_bit_c;
                            sl1_q   <= ~next_bit_c;
                            state_q <= PULSE;
                        end
                    end
                end
                STOP: begin
                    if (tmr_tc_c) begin
                        sl0_q   <= 1'b1;
                        sl1_q   <= 1'b1;
                        state_q <= STOP_GAP;
                    end
                end
                STOP_GAP: begin
                    if (tmr_tc_c) begin
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign sl0  = sl0_q;
    assign sl1  = sl1_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule
